// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
//
// Two-requester front end for a single APB master port. Each requester issues
// a read or write command with a valid/ready handshake. A round-robin arbiter
// picks one command. The FSM then runs a standard APB SETUP/ACCESS transfer
// and returns the result as a one-cycle response strobe to the requester that
// was granted.
//
// Ports
//   i_PCLK, i_PRESETn      clock; synchronous active-low reset
//   i_REQ_VALID/o_REQ_READY per-requester command handshake (ready only in IDLE)
//   i_REQ_WRITE/SLV/ADDR/WDATA  per-requester command fields
//   o_RSP_VALID            one-cycle strobe to the requester that was served
//   o_RSP_RDATA/o_RSP_ERR  response payload; holds its value between strobes
//   o_PADDR..o_PWDATA      APB request side (PSEL is one-hot)
//   i_PREADY/PRDATA/PSLVERR APB completion side
//
// An ACCESS phase that waits TIMEOUT cycles without PREADY is aborted with an
// error. A command to a slave index >= SEL_WIDTH never reaches the bus and is
// answered with an error. TIMEOUT must be at least 1.
// -----------------------------------------------------------------------------
module apb_master_arbiter #(
  parameter int SEL_WIDTH  = 3,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                       i_PCLK,
  input  logic                       i_PRESETn,
  input  logic [1:0]                 i_REQ_VALID,
  output logic [1:0]                 o_REQ_READY,
  input  logic [1:0]                 i_REQ_WRITE,
  input  logic [1:0][1:0]            i_REQ_SLV,
  input  logic [1:0][ADDR_WIDTH-1:0] i_REQ_ADDR,
  input  logic [1:0][DATA_WIDTH-1:0] i_REQ_WDATA,
  output logic [1:0]                 o_RSP_VALID,
  output logic [DATA_WIDTH-1:0]      o_RSP_RDATA,
  output logic                       o_RSP_ERR,
  output logic [ADDR_WIDTH-1:0]      o_PADDR,
  output logic [SEL_WIDTH-1:0]       o_PSEL,
  output logic                       o_PENABLE,
  output logic                       o_PWRITE,
  output logic [DATA_WIDTH-1:0]      o_PWDATA,
  input  logic                       i_PREADY,
  input  logic [DATA_WIDTH-1:0]      i_PRDATA,
  input  logic                       i_PSLVERR
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // The wait count saturates one short of TIMEOUT. The cycle spent at this
  // value is the TIMEOUT-th ACCESS cycle without PREADY.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    grant_q;      // requester being served
  logic                    last_q;       // round-robin pointer: last requester granted
  logic [1:0]              slv_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic [CW-1:0]           wait_cnt_q;

  logic                    grant_d;
  logic                    accept;
  logic [1:0]              slv_sel;
  logic                    slv_ok;

  // When both requesters are valid, the one not served last time wins.
  // Otherwise the single valid requester wins.
  always_comb begin
    grant_d = 1'b0;
    if (i_REQ_VALID == 2'b11) begin
      grant_d = ~last_q;
    end else begin
      grant_d = i_REQ_VALID[1];
    end
  end

  assign accept  = (state_q == IDLE) && (|i_REQ_VALID);
  assign slv_sel = i_REQ_SLV[grant_d];
  assign slv_ok  = (32'(slv_sel) < SEL_WIDTH);

  assign o_REQ_READY = accept ? (grant_d ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      slv_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_q <= grant_d;
            last_q  <= grant_d;
            slv_q   <= slv_sel;
            if (slv_ok) begin
              // APB fields update only for transfers that reach the bus.
              // For bad-index commands they keep the last driven values.
              paddr_q  <= i_REQ_ADDR[grant_d];
              pwrite_q <= i_REQ_WRITE[grant_d];
              pwdata_q <= i_REQ_WDATA[grant_d];
              state_q  <= SETUP;
            end else begin
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end
          end
        end

        SETUP: begin
          wait_cnt_q <= '0;
          state_q    <= ACCESS;
        end

        ACCESS: begin
          if (i_PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : i_PRDATA;
            rsp_err_q   <= i_PSLVERR;
            state_q     <= RESP;
          end else if (wait_cnt_q == WAIT_LAST) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        RESP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Bus and response outputs are decoded from the registered state.
  // A reset therefore clears PSEL/PENABLE/RSP_VALID starting with the next cycle.
  assign o_PSEL      = ((state_q == SETUP) || (state_q == ACCESS))
                       ? (SEL_WIDTH'(1) << slv_q) : '0;
  assign o_PENABLE   = (state_q == ACCESS);
  assign o_PADDR     = paddr_q;
  assign o_PWRITE    = pwrite_q;
  assign o_PWDATA    = pwdata_q;
  assign o_RSP_VALID = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_RSP_RDATA = rsp_rdata_q;
  assign o_RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
//
// Directed bench for apb_master_arbiter at its default parameters.
// The bench drives a linear sequence of commands:
//   - a zero-wait write
//   - a read with wait states
//   - round-robin contention between both requesters
//   - a bad slave index
//   - a clean read
//   - a timeout
//   - a slave error
//   - a reset in the middle of a transfer
// Expected values are hand-computed from the cycle timing:
//   accept in cycle T, SETUP in T+1, ACCESS from T+2, RESP one cycle after
//   PREADY is seen.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

  logic            clk;
  logic            rstn;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_write;
  logic [1:0][1:0] req_slv;
  logic [1:0][1:0] req_addr;
  logic [1:0][7:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [7:0]      rsp_rdata;
  logic            rsp_err;
  logic [1:0]      paddr;
  logic [2:0]      psel;
  logic            penable;
  logic            pwrite;
  logic [7:0]      pwdata;
  logic            pready;
  logic [7:0]      prdata;
  logic            pslverr;

  int n_vec = 0;
  int n_err = 0;

  apb_master_arbiter #(
    .SEL_WIDTH (3),
    .ADDR_WIDTH(2),
    .DATA_WIDTH(8),
    .TIMEOUT   (15)
  ) dut (
    .i_PCLK     (clk),
    .i_PRESETn  (rstn),
    .i_REQ_VALID(req_valid),
    .o_REQ_READY(req_ready),
    .i_REQ_WRITE(req_write),
    .i_REQ_SLV  (req_slv),
    .i_REQ_ADDR (req_addr),
    .i_REQ_WDATA(req_wdata),
    .o_RSP_VALID(rsp_valid),
    .o_RSP_RDATA(rsp_rdata),
    .o_RSP_ERR  (rsp_err),
    .o_PADDR    (paddr),
    .o_PSEL     (psel),
    .o_PENABLE  (penable),
    .o_PWRITE   (pwrite),
    .o_PWDATA   (pwdata),
    .i_PREADY   (pready),
    .i_PRDATA   (prdata),
    .i_PSLVERR  (pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 2 time units after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] exp_rdy  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [2:0] exp_psel [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

  initial begin
    logic [7:0] e_rd;
    rstn = 1'b0; req_valid = '0; req_write = '0; req_slv = '0; req_addr = '0;
    req_wdata = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;

    // ---- reset state ----
    tick; tick;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_psel", psel, 3'b000);
    chk("rst_penable", penable, 1'b0);
    chk("rst_paddr", paddr, 2'b00);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_pwdata", pwdata, 8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_err", rsp_err, 1'b0);
    rstn = 1'b1;
    tick;

    // ---- A: zero-wait write, req0, slv1, addr2, 0x5A ----
    req_valid = 2'b01; req_write = 2'b01; req_slv[0] = 2'd1; req_addr[0] = 2'd2;
    req_wdata[0] = 8'h5A; pready = 1'b1;
    #1 chk("A_ready", req_ready, 2'b01);
    tick;                                   // T+1 SETUP
    req_valid = 2'b00; req_addr[0] = 2'd0; req_wdata[0] = 8'hFF;
    #1;
    chk("A_setup_ready", req_ready, 2'b00);
    chk("A_setup_psel", psel, 3'b010);
    chk("A_setup_penable", penable, 1'b0);
    chk("A_setup_paddr", paddr, 2'd2);
    chk("A_setup_pwrite", pwrite, 1'b1);
    chk("A_setup_pwdata", pwdata, 8'h5A);
    tick;                                   // T+2 ACCESS
    chk("A_access_psel", psel, 3'b010);
    chk("A_access_penable", penable, 1'b1);
    chk("A_access_rsp_valid", rsp_valid, 2'b00);
    tick;                                   // T+3 RESP
    chk("A_rsp_valid", rsp_valid, 2'b01);
    chk("A_rsp_err", rsp_err, 1'b0);
    chk("A_rsp_psel", psel, 3'b000);
    chk("A_rsp_penable", penable, 1'b0);
    chk("A_rsp_paddr_hold", paddr, 2'd2);
    tick;                                   // back in IDLE
    chk("A_idle_rsp_valid", rsp_valid, 2'b00);

    // ---- B: read, req1, slv1, addr1, two wait cycles, 0x3C ----
    req_valid = 2'b10; req_write = 2'b00; req_slv[1] = 2'd1; req_addr[1] = 2'd1;
    pready = 1'b0;
    #1 chk("B_ready", req_ready, 2'b10);
    tick;                                   // T+1
    req_valid = 2'b00;
    chk("B_setup_psel", psel, 3'b010);
    chk("B_setup_pwrite", pwrite, 1'b0);
    chk("B_setup_paddr", paddr, 2'd1);
    tick;                                   // T+2 ACCESS, wait 1
    chk("B_access1_penable", penable, 1'b1);
    tick;                                   // T+3 ACCESS, wait 2
    chk("B_access2_rsp_valid", rsp_valid, 2'b00);
    tick;                                   // T+4 ACCESS, ready
    chk("B_access3_penable", penable, 1'b1);
    pready = 1'b1; prdata = 8'h3C;
    tick;                                   // T+5 RESP
    chk("B_rsp_valid", rsp_valid, 2'b10);
    chk("B_rsp_rdata", rsp_rdata, 8'h3C);
    chk("B_rsp_err", rsp_err, 1'b0);
    prdata = 8'h00;
    tick;

    // ---- C: both requesters valid for four transactions ----
    req_valid = 2'b11; req_write = 2'b00; req_slv[0] = 2'd0; req_slv[1] = 2'd2;
    req_addr[0] = 2'd3; req_addr[1] = 2'd0; pready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e_rd = 8'hA0 + 8'(k);
      prdata = e_rd;
      #1 chk("C_ready", req_ready, exp_rdy[k]);
      tick;                                 // SETUP: other requester waits
      chk("C_setup_ready", req_ready, 2'b00);
      chk("C_setup_psel", psel, exp_psel[k]);
      tick;                                 // ACCESS
      chk("C_access_ready", req_ready, 2'b00);
      tick;                                 // RESP
      chk("C_rsp_ready", req_ready, 2'b00);
      chk("C_rsp_valid", rsp_valid, exp_rdy[k]);
      chk("C_rsp_rdata", rsp_rdata, e_rd);
      tick;
    end
    req_valid = 2'b00;

    // ---- D: slave index 3, req1 -> error at T+1, no bus activity ----
    req_valid = 2'b10; req_slv[1] = 2'd3;
    #1 chk("D_ready", req_ready, 2'b10);
    tick;                                   // T+1 RESP
    req_valid = 2'b00;
    chk("D_psel", psel, 3'b000);
    chk("D_penable", penable, 1'b0);
    chk("D_rsp_valid", rsp_valid, 2'b10);
    chk("D_rsp_err", rsp_err, 1'b1);
    chk("D_rsp_rdata", rsp_rdata, 8'h00);
    chk("D_paddr_hold", paddr, 2'd0);
    tick;
    chk("D_idle_rsp_valid", rsp_valid, 2'b00);

    // ---- E: clean zero-wait read, req0, slv2 ----
    req_valid = 2'b01; req_write = 2'b00; req_slv[0] = 2'd2; req_addr[0] = 2'd1;
    prdata = 8'h77; pready = 1'b1;
    #1 chk("E_ready", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    chk("E_setup_psel", psel, 3'b100);
    tick; tick;
    chk("E_rsp_valid", rsp_valid, 2'b01);
    chk("E_rsp_err", rsp_err, 1'b0);
    chk("E_rsp_rdata", rsp_rdata, 8'h77);
    tick;

    // ---- F: slave never ready -> abort after 15 ACCESS cycles ----
    req_valid = 2'b01; req_write = 2'b01; req_slv[0] = 2'd0; req_wdata[0] = 8'hC3;
    pready = 1'b0;
    #1 chk("F_ready", req_ready, 2'b01);
    tick;                                   // SETUP
    req_valid = 2'b00;
    chk("F_setup_psel", psel, 3'b001);
    for (int i = 0; i < 15; i++) begin
      tick;
      chk("F_access_penable", penable, 1'b1);
    end
    tick;                                   // RESP after the 15th ACCESS cycle
    chk("F_rsp_valid", rsp_valid, 2'b01);
    chk("F_rsp_err", rsp_err, 1'b1);
    chk("F_rsp_rdata", rsp_rdata, 8'h00);
    chk("F_rsp_psel", psel, 3'b000);
    chk("F_rsp_penable", penable, 1'b0);
    tick;

    // ---- G: read with PSLVERR, req1, slv0 ----
    req_valid = 2'b10; req_write = 2'b00; req_slv[1] = 2'd0; req_addr[1] = 2'd2;
    pready = 1'b1; prdata = 8'h55; pslverr = 1'b1;
    #1 chk("G_ready", req_ready, 2'b10);
    tick;
    req_valid = 2'b00;
    tick; tick;
    chk("G_rsp_valid", rsp_valid, 2'b10);
    chk("G_rsp_err", rsp_err, 1'b1);
    chk("G_rsp_rdata", rsp_rdata, 8'h55);
    pslverr = 1'b0;
    tick;

    // ---- H: reset during ACCESS, then arbitration restarts at req0 ----
    req_valid = 2'b01; req_write = 2'b01; req_slv[0] = 2'd1; req_wdata[0] = 8'h99;
    pready = 1'b0;
    #1 chk("H_ready", req_ready, 2'b01);
    tick;                                   // SETUP
    req_valid = 2'b00;
    tick;                                   // ACCESS
    chk("H_access_penable", penable, 1'b1);
    chk("H_access_psel", psel, 3'b010);
    rstn = 1'b0;
    tick;                                   // cycle after the reset edge
    chk("H_rst_psel", psel, 3'b000);
    chk("H_rst_penable", penable, 1'b0);
    chk("H_rst_rsp_valid", rsp_valid, 2'b00);
    chk("H_rst_pwdata", pwdata, 8'h00);
    chk("H_rst_rdata", rsp_rdata, 8'h00);
    rstn = 1'b1;
    tick;
    chk("H_post_rsp_valid", rsp_valid, 2'b00);
    tick;
    chk("H_post2_rsp_valid", rsp_valid, 2'b00);
    req_valid = 2'b11; req_write = 2'b00; req_slv[0] = 2'd0; req_slv[1] = 2'd1;
    pready = 1'b1; prdata = 8'h12;
    #1 chk("H_grant_req0", req_ready, 2'b01);
    tick;
    req_valid = 2'b00;
    chk("H_setup_psel", psel, 3'b001);
    tick; tick;
    chk("H_rsp_valid", rsp_valid, 2'b01);
    chk("H_rsp_rdata", rsp_rdata, 8'h12);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameters: SEL_WIDTH, default 3, number of one-hot PSEL lines; ADDR_WIDTH, default 2, PADDR width; DATA_WIDTH, default 8, data width; TIMEOUT, default 15, maximum ACCESS wait cycles.
REQ-002 SHALL have the following ports, in this order:
- i_PCLK  in  1  single clock; all logic on rising edge.
- i_PRESETn  in  1  reset; synchronous, active-low.
- i_REQ_VALID  in  [1:0]  per-requester command valid.
- o_REQ_READY  out  [1:0]  per-requester command accept.
- i_REQ_WRITE  in  [1:0]  1 = write, 0 = read.
- i_REQ_SLV  in  [1:0][1:0]  target slave index.
- i_REQ_ADDR  in  [1:0][ADDR_WIDTH-1:0]  register address.
- i_REQ_WDATA  in  [1:0][DATA_WIDTH-1:0]  write data.
- o_RSP_VALID  out  [1:0]  one-cycle response strobe.
- o_RSP_RDATA  out  [DATA_WIDTH-1:0]  read data for the strobed requester.
- o_RSP_ERR  out  1  error for the strobed requester.
- o_PADDR  out  ADDR_WIDTH  APB address.
- o_PSEL  out  SEL_WIDTH  APB select, one-hot.
- o_PENABLE  out  1  APB enable.
- o_PWRITE  out  1  APB direction.
- o_PWDATA  out  DATA_WIDTH  APB write data.
- i_PREADY  in  1  APB ready.
- i_PRDATA  in  DATA_WIDTH  APB read data.
- i_PSLVERR  in  1  APB slave error.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP, all outputs decoded from registered state and latched command.
REQ-004 IDLE: if any i_REQ_VALID, SHALL grant one requester, assert o_REQ_READY[grant] combinationally in the same cycle; command latched at that edge; next state SETUP, or RESP if i_REQ_SLV >= SEL_WIDTH.
REQ-005 Arbitration SHALL be round-robin: when both are valid, grant the requester not granted last; last-grant pointer resets to 1, so requester 0 wins first.
REQ-006 o_REQ_READY SHALL be 0 in every state except IDLE, and at most one bit SHALL be set.
REQ-007 SETUP: o_PSEL = 1<<slv, o_PENABLE = 0, o_PADDR/o_PWRITE/o_PWDATA = latched values; next state ACCESS unconditionally.
REQ-008 ACCESS: o_PSEL unchanged, o_PENABLE = 1, address/data/direction stable; on i_PREADY=1 capture i_PRDATA (reads; 0 for writes) and i_PSLVERR; next state RESP.
REQ-009 ACCESS wait counter SHALL start at 0 on entry and increment each cycle with i_PREADY=0; when it reaches TIMEOUT, the block SHALL abort to RESP with err=1, rdata=0.
REQ-010 Invalid slave index (>= SEL_WIDTH) SHALL produce no APB activity (PSEL stays 0), with response err=1, rdata=0.
REQ-011 RESP: o_RSP_VALID[grant]=1 for exactly one cycle, with o_RSP_RDATA/o_RSP_ERR valid; next state IDLE.
REQ-012 Outside RESP, o_RSP_VALID SHALL be 0 and o_RSP_RDATA/o_RSP_ERR SHALL hold last value.
REQ-013 Outside SETUP/ACCESS, o_PSEL SHALL be 0 and o_PENABLE 0; o_PADDR/o_PWRITE/o_PWDATA SHALL hold last driven values.
REQ-014 Latency: accept at edge T, SETUP in T+1, ACCESS in T+2; with zero-wait slave, RESP in T+3; next accept possible in T+4.
REQ-015 A requester dropping i_REQ_VALID after acceptance SHALL NOT affect the transaction in flight.
REQ-016 New requests arriving during SETUP/ACCESS/RESP SHALL wait (ready=0) without loss while valid is held.

Reset
REQ-017 On a rising edge with i_PRESETn=0: state IDLE; all outputs 0; wait counter 0; last-grant = 1.
REQ-018 Reset mid-transaction SHALL abort it silently: no o_RSP_VALID is issued, and o_PSEL/o_PENABLE are 0 in the cycle after the reset edge.

Verification
REQ-019 Write, req0, slv=1, addr=2, wdata=0x5A, zero-wait slave -> o_PSEL=3'b010; PENABLE high for 1 cycle; o_RSP_VALID=2'b01 at T+3, err=0.
REQ-020 Read, req1, slv=1, addr=1, slave returns 0x3C after 2 wait cycles -> o_RSP_VALID=2'b10 at T+5, rdata=0x3C, err=0.
REQ-021 Both requesters valid continuously for 4 transactions -> grant order 0,1,0,1; o_REQ_READY never 2'b11.
REQ-022 Slave holds i_PREADY=0 -> abort after TIMEOUT=15 ACCESS cycles; rsp err=1, rdata=0x00; o_PSEL returns to 0.
REQ-023 Slave index 3, and separately PSLVERR=1 on a read -> index 3 gives no PSEL activity, err=1 at T+1; PSLVERR case gives err=1.
REQ-024 i_PRESETn low during ACCESS -> next cycle PSEL=0, PENABLE=0, no RSP_VALID; the next request after reset is granted to req0.
